// File: rtl/stream_packet_buffer_if.sv
// Stream bus bundle (data, byte strobes, valid/ready, last) for the packet buffer ports.
// The master drives the payload and valid; the slave drives ready.
interface stream_packet_buffer_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic                    tvalid;
    logic                    tlast;
    logic                    tready;

    modport master (output tdata, output tstrb, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tstrb, input tvalid, input tlast, output tready);
endinterface

// File: rtl/stream_packet_buffer.sv
// Store-and-forward packet buffer: stores a whole packet, then replays it; first replay beat 2 edges after tlast accept.
// Upstream ready only in FILL (no intake during replay); replay holds outputs while downstream is not ready.
module stream_packet_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                          s01_axis_aclk,
    input  logic                          s01_axis_areset,
    stream_packet_buffer_if.slave         s01_axis,
    stream_packet_buffer_if.master        m01_axis,
    output logic                          overflow
);
    localparam int STRB_W  = DATA_WIDTH / 8;
    localparam int ADDR_W  = $clog2(DEPTH);
    localparam int PTR_W   = ADDR_W + 1;
    localparam int ENTRY_W = DATA_WIDTH + STRB_W;
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] ONE_P   = PTR_W'(1);

    typedef enum logic [1:0] {FILL, LOAD, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [PTR_W-1:0]      wr_count_q, wr_count_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      len_q, len_d;
    logic                  overflow_q, overflow_d;
    logic                  s_rdy_q, s_rdy_d;
    logic                  m_vld_q, m_vld_d;
    logic                  m_last_q, m_last_d;
    logic [DATA_WIDTH-1:0] m_dat_q, m_dat_d;
    logic [STRB_W-1:0]     m_stb_q, m_stb_d;

    logic [ENTRY_W-1:0]    mem [DEPTH];
    logic [ENTRY_W-1:0]    rd_entry;
    logic [ADDR_W-1:0]     rd_addr;
    logic [PTR_W-1:0]      rd_ptr_nxt;
    logic                  mem_we;
    logic                  s_acc;
    logic                  m_hs;
    logic                  wr_full;

    assign s_acc      = s01_axis.tvalid & s_rdy_q;
    assign m_hs       = m01_axis.tready & m_vld_q;
    assign wr_full    = (wr_count_q == DEPTH_P);
    assign rd_ptr_nxt = rd_ptr_q + 1'b1;
    // LOAD always fetches entry 0; DRAIN prefetches the entry after the one on the bus.
    assign rd_addr    = (state_q == LOAD) ? '0 : rd_ptr_nxt[ADDR_W-1:0];
    assign rd_entry   = mem[rd_addr];

    always_comb begin
        state_d    = state_q;
        wr_count_d = wr_count_q;
        rd_ptr_d   = rd_ptr_q;
        len_d      = len_q;
        overflow_d = overflow_q;
        s_rdy_d    = s_rdy_q;
        m_vld_d    = m_vld_q;
        m_last_d   = m_last_q;
        m_dat_d    = m_dat_q;
        m_stb_d    = m_stb_q;
        mem_we     = 1'b0;

        case (state_q)
            FILL: begin
                s_rdy_d = 1'b1;
                if (s_acc) begin
                    if (wr_count_q == '0) begin
                        overflow_d = 1'b0;
                    end
                    // Beats beyond capacity are dropped but the packet still ends on its tlast.
                    if (wr_full) begin
                        overflow_d = 1'b1;
                    end else begin
                        mem_we     = 1'b1;
                        wr_count_d = wr_count_q + 1'b1;
                    end
                    if (s01_axis.tlast) begin
                        state_d = LOAD;
                        s_rdy_d = 1'b0;
                        len_d   = wr_full ? DEPTH_P : wr_count_q + 1'b1;
                    end
                end
            end
            LOAD: begin
                m_dat_d  = rd_entry[ENTRY_W-1:STRB_W];
                m_stb_d  = rd_entry[STRB_W-1:0];
                m_vld_d  = 1'b1;
                m_last_d = (len_q == ONE_P);
                rd_ptr_d = '0;
                state_d  = DRAIN;
            end
            DRAIN: begin
                if (m_hs) begin
                    if (m_last_q) begin
                        m_vld_d    = 1'b0;
                        m_last_d   = 1'b0;
                        wr_count_d = '0;
                        s_rdy_d    = 1'b1;
                        state_d    = FILL;
                    end else begin
                        rd_ptr_d = rd_ptr_nxt;
                        m_dat_d  = rd_entry[ENTRY_W-1:STRB_W];
                        m_stb_d  = rd_entry[STRB_W-1:0];
                        m_last_d = (rd_ptr_nxt == len_q - 1'b1);
                    end
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge s01_axis_aclk or posedge s01_axis_areset) begin
        if (s01_axis_areset) begin
            state_q    <= FILL;
            wr_count_q <= '0;
            rd_ptr_q   <= '0;
            len_q      <= '0;
            overflow_q <= 1'b0;
            s_rdy_q    <= 1'b0;
            m_vld_q    <= 1'b0;
            m_last_q   <= 1'b0;
            m_dat_q    <= '0;
            m_stb_q    <= '0;
        end else begin
            state_q    <= state_d;
            wr_count_q <= wr_count_d;
            rd_ptr_q   <= rd_ptr_d;
            len_q      <= len_d;
            overflow_q <= overflow_d;
            s_rdy_q    <= s_rdy_d;
            m_vld_q    <= m_vld_d;
            m_last_q   <= m_last_d;
            m_dat_q    <= m_dat_d;
            m_stb_q    <= m_stb_d;
        end
    end

    always_ff @(posedge s01_axis_aclk) begin
        if (mem_we) begin
            mem[wr_count_q[ADDR_W-1:0]] <= {s01_axis.tdata, s01_axis.tstrb};
        end
    end

    assign s01_axis.tready = s_rdy_q;
    assign m01_axis.tvalid = m_vld_q;
    assign m01_axis.tlast  = m_last_q;
    assign m01_axis.tdata  = m_dat_q;
    assign m01_axis.tstrb  = m_stb_q;
    assign overflow        = overflow_q;
endmodule

// File: tb/tb_stream_packet_buffer.sv
// Scoreboard bench for stream_packet_buffer: stimulus queues expected replay beats, a negedge monitor checks them.
module tb_stream_packet_buffer;
    localparam int DW    = 32;
    localparam int SW    = DW / 8;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic [DW-1:0] dat;
        logic [SW-1:0] stb;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic overflow;

    stream_packet_buffer_if #(.DATA_WIDTH(DW)) s_if ();
    stream_packet_buffer_if #(.DATA_WIDTH(DW)) m_if ();

    stream_packet_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .s01_axis_aclk   (clk),
        .s01_axis_areset (rst),
        .s01_axis        (s_if),
        .m01_axis        (m_if),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    n_out = 0;
    bit    rdy_toggle = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [SW-1:0] strb_of(input logic [DW-1:0] d, input bit full);
        logic [3:0] s;
        s = d[3:0] ^ 4'h5;
        return full ? 4'hF : s;
    endfunction

    // Monitor: every cycle a beat is presented it must match the queue head; pop on handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && m_if.tvalid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_beat: got 0x%0h, want no beat", m_if.tdata);
                end else begin
                    chk("out_dat",  m_if.tdata, exp_q[0].dat);
                    chk("out_stb",  m_if.tstrb, exp_q[0].stb);
                    chk("out_last", m_if.tlast, exp_q[0].last);
                    if (m_if.tready) begin
                        void'(exp_q.pop_front());
                        n_out++;
                    end
                end
            end
        end
    end

    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_if.tready = rdy_toggle ? ~m_if.tready : 1'b1;
        end
    end

    task automatic send_beat(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic last);
        s_if.tdata  = d;
        s_if.tstrb  = s;
        s_if.tlast  = last;
        s_if.tvalid = 1'b1;
        for (int w = 0; w < 200 && !s_if.tready; w++) begin
            @(posedge clk);
            #1;
        end
        if (!s_if.tready) begin
            n_cmp++;
            n_err++;
            $display("FAIL in_rdy_timeout: got 0, want 1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int n, input logic [DW-1:0] base, input bit full);
        int stored;
        stored = (n > DEPTH) ? DEPTH : n;
        for (int i = 0; i < stored; i++) begin
            exp_q.push_back(beat_t'{dat: base + DW'(i), stb: strb_of(base + DW'(i), full),
                                    last: (i == stored - 1)});
        end
    endtask

    // Sends a packet and checks the LOAD cycle and first replay cycle timing.
    task automatic send_pkt(input int n, input logic [DW-1:0] base, input bit full);
        push_exp(n, base, full);
        for (int i = 0; i < n; i++) begin
            send_beat(base + DW'(i), strb_of(base + DW'(i), full), (i == n - 1));
            if (i == 0) chk("ovf_clear_first", overflow, 0);
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        chk("lat_load_vld", m_if.tvalid, 0);
        chk("ovf_after_last", overflow, (n > DEPTH));
        @(posedge clk);
        #1;
        chk("lat_vld", m_if.tvalid, 1);
        chk("in_rdy_drain", s_if.tready, 0);
        chk("ovf_hold", overflow, (n > DEPTH));
    endtask

    task automatic wait_drain();
        for (int w = 0; w < 500 && (exp_q.size() != 0 || m_if.tvalid); w++) begin
            @(posedge clk);
            #1;
        end
        if (exp_q.size() != 0 || m_if.tvalid) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending, want 0", exp_q.size());
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, want completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tdata  = '0;
        s_if.tstrb  = '0;

        // Reset values, then ready rises one edge after release.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_rdy", s_if.tready, 0);
        chk("rst_m_vld", m_if.tvalid, 0);
        chk("rst_m_last", m_if.tlast, 0);
        chk("rst_m_dat", m_if.tdata, 0);
        chk("rst_m_stb", m_if.tstrb, 0);
        chk("rst_ovf", overflow, 0);
        rst = 1'b0;
        chk("rel_rdy_before_edge", s_if.tready, 0);
        @(posedge clk);
        #1;
        chk("rel_rdy_after_edge", s_if.tready, 1);

        // Single beat; ready returns the cycle after the replay handshake.
        send_pkt(1, 32'hA5A5_0001, 1'b1);
        chk("single_rdy_during_vld", s_if.tready, 0);
        @(posedge clk);
        #1;
        chk("single_rdy_after_hs", s_if.tready, 1);
        chk("single_vld_after_hs", m_if.tvalid, 0);

        // Four beats with downstream ready toggling.
        rdy_toggle = 1'b1;
        send_pkt(4, 32'h10, 1'b0);
        wait_drain();
        chk("toggle_ovf", overflow, 0);
        rdy_toggle = 1'b0;

        // Truncated packet: 20 beats into 16 entries.
        send_pkt(20, 32'h0, 1'b0);
        wait_drain();
        chk("trunc_ovf_sticky", overflow, 1);

        // Exactly DEPTH beats, overflow must clear and stay clear.
        send_pkt(DEPTH, 32'h100, 1'b0);
        wait_drain();
        chk("full_ovf", overflow, 0);

        // Upstream beat held valid through DRAIN is taken on the first FILL cycle.
        send_pkt(3, 32'h20, 1'b0);
        push_exp(1, 32'h30, 1'b0);
        s_if.tdata  = 32'h30;
        s_if.tstrb  = strb_of(32'h30, 1'b0);
        s_if.tlast  = 1'b1;
        s_if.tvalid = 1'b1;
        for (int w = 0; w < 50 && m_if.tvalid; w++) begin
            chk("held_rdy_drain", s_if.tready, 0);
            @(posedge clk);
            #1;
        end
        chk("held_rdy_fill", s_if.tready, 1);
        @(posedge clk);
        #1;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        chk("held_accepted", s_if.tready, 0);
        wait_drain();

        // Reset after two of four beats replayed.
        n0 = n_out;
        send_pkt(4, 32'h40, 1'b1);
        for (int w = 0; w < 100 && n_out < n0 + 2; w++) begin
            @(posedge clk);
            #1;
        end
        chk("mid_two_beats_out", n_out - n0, 2);
        rst = 1'b1;
        #1;
        exp_q.delete();
        chk("mid_rst_vld", m_if.tvalid, 0);
        chk("mid_rst_last", m_if.tlast, 0);
        chk("mid_rst_rdy", s_if.tready, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rel_rdy_before", s_if.tready, 0);
        @(posedge clk);
        #1;
        chk("mid_rel_rdy_after", s_if.tready, 1);
        send_pkt(2, 32'h50, 1'b0);
        wait_drain();

        chk("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
